scan_sequencer: RTL
===================

# scan_sequencer

Generates the 2-bit select (`i0`, `i1`) that drives the 2-to-4 decoder. It steps through the enabled decoder channels in ascending order and holds each select value for a programmable dwell time. It supports single-sweep and continuous modes, with a one-cycle done pulse at the end of each sweep. It sits directly upstream of the decoder, and its select outputs connect straight to the decoder inputs.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a sweep; sampled on `clk`.
- `stop`  in  1  aborts the sweep in progress; sampled on `clk`.
- `mode`  in  1  0 = single sweep, 1 = continuous; captured at start.
- `mask`  in  4  channel-enable mask, bit n = decoder channel n; captured at start.
- `dwell`  in  DWELL_W  each channel is held for `dwell`+1 cycles; captured at start.
- `i0`  out  1  select LSB; feeds decoder `i0`.
- `i1`  out  1  select MSB; feeds decoder `i1`.
- `valid`  out  1  select is active, so the decoder output is meaningful.
- `busy`  out  1  sweep in progress; equals `valid`.
- `sweep_done`  out  1  one-cycle pulse when the highest enabled channel finishes.

## Operation
- Registers:
  - state: IDLE or SCAN.
  - `sel[1:0]`, driving `i1`/`i0`.
  - dwell counter, `DWELL_W` bits.
  - `mask_q`, `dwell_q`, `mode_q`.
  - `sweep_done` flag.
- All outputs are registered. On reset:
  - `i0`=0, `i1`=0, `valid`=0, `busy`=0, `sweep_done`=0.
  - state=IDLE, counter=0.
  - `mask_q`=0, `dwell_q`=0, `mode_q`=0.
- IDLE:
  - `start`=1 and `mask`≠0: capture `mask`/`dwell`/`mode`, set `sel` to the lowest set bit of `mask`, counter=0, and go to SCAN.
  - `start`=1 and `mask`=0: ignored; stay in IDLE with no pulse.
  - `sel` holds its last value while in IDLE.
- SCAN, every cycle:
  - counter < `dwell_q`: counter+1.
  - counter = `dwell_q`: counter=0, then move to the next set bit of `mask_q` above `sel`.
    - If a higher set bit exists, advance `sel` to it.
    - If none exists (end of sweep), assert `sweep_done` for one cycle.
    - End of sweep with `mode_q`=1: `sel` wraps to the lowest set bit, and the state stays SCAN.
    - End of sweep with `mode_q`=0: go to IDLE with `valid`=0, and `sel` holds the last channel.
- `stop`=1 in SCAN: go to IDLE on the next edge with `valid`=0 and counter=0.
  - `stop` suppresses `sweep_done`, even on an end-of-sweep cycle.
- `start` and `stop` in the same IDLE cycle: `stop` wins, and the block stays in IDLE.
- `start` in SCAN is ignored.
- Changes to `mask`/`dwell`/`mode` during SCAN have no effect until the next start.
- Single enabled channel, continuous mode: `sel` stays constant and `sweep_done` pulses every `dwell`+1 cycles.
- Reset asserted mid-sweep clears all outputs immediately and asynchronously. Once reset is released, the block idles until the next `start`.

## Timing
- Latency: `start` sampled at edge k gives `valid`=1 and the first `sel` at edge k, i.e. visible from cycle k+1.
- Each enabled channel is held for exactly `dwell`+1 cycles, back to back, with no gap cycles between channels.
- A sweep lasts N×(`dwell`+1) cycles, where N = popcount(`mask_q`).
- `sweep_done` is high in the cycle immediately after the last cycle of the highest channel:
  - in continuous mode, concurrent with the first channel of the next sweep;
  - in single mode, concurrent with `valid`=0.
- `stop` sampled at edge k gives `valid`=0 at edge k.
- There is no combinational path from any input to any output.

## Test plan
- Reset: hold `rst`=1 while driving `start`=1 → all outputs 0. Assert `rst` asynchronously between clock edges → outputs clear before the next edge.
- Single sweep, `mask`=1111, `dwell`=0, `mode`=0, one-cycle `start` → `sel` = 0,1,2,3 on four consecutive cycles with `valid`=1. On the fifth cycle, `sweep_done`=1 and `valid`=0.
- Masked dwell, `mask`=1010, `dwell`=2, `mode`=0 → `sel`=1 for 3 cycles, then `sel`=3 for 3 cycles, then `sweep_done` pulses and the block returns to IDLE. `mask` changed to 0001 mid-sweep has no effect.
- Continuous, `mask`=0101, `dwell`=1, `mode`=1 → `sel` pattern 0,0,2,2,0,0,2,2… with `sweep_done` high on each return to 0 (cycles 5, 9, …).
- Stop and `start`/`stop` conflict:
  - `stop` pulsed during `sel`=2 of a sweep on `mask`=1111 → `valid`=0 next cycle, no `sweep_done`, and `i1`/`i0` hold 1/0.
  - `start`=`stop`=1 in IDLE → the block stays in IDLE.
- `mask`=0 with `start` → no change; `valid`, `busy`, and `sweep_done` remain 0.

Source files
------------

// File: rtl/scan_sequencer.sv
// Select sequencer for a 2-to-4 decoder.
// Walks enabled channels in ascending order with a programmable dwell per channel.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               i0,
    output logic               i1,
    output logic               valid,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [1:0]         sel, sel_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_q_n;
    logic [3:0]         mask_q, mask_q_n;
    logic               mode_q, mode_q_n;
    logic               done_q, done_n;
    logic               has_next;
    logic [1:0]         next_sel;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Find the next enabled channel strictly above the current select.
    always_comb begin
        has_next = 1'b0;
        next_sel = sel;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel))) begin
                has_next = 1'b1;
                next_sel = 2'(i);
            end
        end
    end

    // Next-state logic: capture on start, dwell counting, channel advance.
    always_comb begin
        state_n   = state;
        sel_n     = sel;
        cnt_n     = cnt;
        dwell_q_n = dwell_q;
        mask_q_n  = mask_q;
        mode_q_n  = mode_q;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop && (mask != 4'd0)) begin
                    mask_q_n  = mask;
                    dwell_q_n = dwell;
                    mode_q_n  = mode;
                    sel_n     = lowest(mask);
                    cnt_n     = '0;
                    state_n   = SCAN;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt < dwell_q) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (has_next) begin
                        sel_n = next_sel;
                    end else begin
                        done_n = 1'b1;
                        if (mode_q) sel_n = lowest(mask_q);
                        else state_n = IDLE;
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 2'd0;
            cnt     <= '0;
            dwell_q <= '0;
            mask_q  <= 4'd0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            cnt     <= cnt_n;
            dwell_q <= dwell_q_n;
            mask_q  <= mask_q_n;
            mode_q  <= mode_q_n;
            done_q  <= done_n;
        end
    end

    assign i0         = sel[0];
    assign i1         = sel[1];
    assign valid      = (state == SCAN);
    assign busy       = (state == SCAN);
    assign sweep_done = done_q;

endmodule
